// File: rtl/div_pkg.sv
// Shared types and helpers for the divide issue controller.
// The special-case predicate is kept here so other fast paths can reuse it.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } div_state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Divide-by-zero, or the one signed quotient that cannot be represented.
  function automatic logic is_special(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    return (b == '0) || (op_is_signed(op) && (a == INT_MIN) && (b == ALL_ONES));
  endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational detect and architectural result for x/0 and INT_MIN/-1,
// so these ops never need to occupy the divider.
module div_special_case
  import div_pkg::*;
(
  input  div_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        special,
  output logic [31:0] result
);

  always_comb begin
    special = is_special(op, a, b);
    if (b == '0) begin
      result = op_is_rem(op) ? a : ALL_ONES;
    end else begin
      // Only reached as a special case for signed overflow.
      result = op_is_rem(op) ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Initiator side of the divider handshake: accepts divide ops, issues them to the
// divider (or answers corner cases locally), holds the result for writeback, handles flush.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int BYPASS_SPECIAL = 1,
  parameter int XLEN           = 32
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic            div_signed_o,
  output logic            div_in_valid_o,
  input  logic            div_in_ready_i,
  input  logic            div_out_valid_i,
  output logic            div_out_ready_o,
  input  logic [XLEN-1:0] div_q_i,
  input  logic [XLEN-1:0] div_r_i
);

  div_state_e      state;
  div_op_e         op;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic            accept;
  logic            bypass;
  logic            rem_sel;

  assign op     = div_op_e'(req_op_i);
  // A request arriving with a flush is dropped rather than accepted.
  assign accept = req_valid_i && req_ready_o && !flush_i;
  assign bypass = (BYPASS_SPECIAL != 0) && special;

  div_special_case u_special (
    .op      (op),
    .a       (req_rs1_i),
    .b       (req_rs2_i),
    .special (special),
    .result  (special_result)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      req_ready_o     <= 1'b0;
      busy_o          <= 1'b0;
      wb_valid_o      <= 1'b0;
      wb_data_o       <= '0;
      wb_rd_o         <= '0;
      div_a_o         <= '0;
      div_b_o         <= '0;
      div_signed_o    <= 1'b0;
      div_in_valid_o  <= 1'b0;
      div_out_ready_o <= 1'b0;
      rem_sel         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_a_o      <= req_rs1_i;
            div_b_o      <= req_rs2_i;
            div_signed_o <= op_is_signed(op);
            rem_sel      <= op_is_rem(op);
            wb_rd_o      <= req_rd_i;
            req_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            if (bypass) begin
              state      <= RESP;
              wb_valid_o <= 1'b1;
              wb_data_o  <= special_result;
            end else begin
              state          <= ISSUE;
              div_in_valid_o <= 1'b1;
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (div_in_ready_i) begin
            // Transfer has happened; a flush now must still absorb the response.
            div_in_valid_o  <= 1'b0;
            div_out_ready_o <= 1'b1;
            if (flush_i) begin
              state  <= DRAIN;
              busy_o <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end else if (flush_i) begin
            div_in_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            req_ready_o    <= 1'b1;
            state          <= IDLE;
          end
        end
        WAIT: begin
          if (div_out_valid_i) begin
            div_out_ready_o <= 1'b0;
            if (flush_i) begin
              busy_o      <= 1'b0;
              req_ready_o <= 1'b1;
              state       <= IDLE;
            end else begin
              wb_valid_o <= 1'b1;
              wb_data_o  <= rem_sel ? div_r_i : div_q_i;
              state      <= RESP;
            end
          end else if (flush_i) begin
            busy_o <= 1'b0;
            state  <= DRAIN;
          end
        end
        RESP: begin
          if (flush_i || wb_ready_i) begin
            wb_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        DRAIN: begin
          if (div_out_valid_i) begin
            div_out_ready_o <= 1'b0;
            req_ready_o     <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural multi-cycle divider and a writeback scoreboard.
module tb_div_issue_ctrl;

  logic        clock = 1'b0;
  logic        nreset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_rs1_i;
  logic [31:0] req_rs2_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] div_a_o;
  logic [31:0] div_b_o;
  logic        div_signed_o;
  logic        div_in_valid_o;
  logic        div_in_ready_i;
  logic        div_out_valid_i;
  logic        div_out_ready_o;
  logic [31:0] div_q_i;
  logic [31:0] div_r_i;

  int compared   = 0;
  int mismatched = 0;
  int div_starts = 0;
  logic wb_seen  = 1'b0;
  logic [36:0] exp_q[$];

  always #5 clock = ~clock;

  div_issue_ctrl #(.BYPASS_SPECIAL(1), .XLEN(32)) dut (
    .clock(clock), .nreset(nreset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i), .busy_o(busy_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_signed_o(div_signed_o),
    .div_in_valid_o(div_in_valid_o), .div_in_ready_i(div_in_ready_i),
    .div_out_valid_i(div_out_valid_i), .div_out_ready_o(div_out_ready_o),
    .div_q_i(div_q_i), .div_r_i(div_r_i)
  );

  // RISC-V divide semantics: returns {quotient, remainder}.
  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  // Behavioural divider: fixed latency, result valid only while done.
  logic        dm_busy, dm_done;
  int          dm_cnt;
  logic [31:0] dm_q, dm_r;
  assign div_in_ready_i  = !dm_busy;
  assign div_out_valid_i = dm_done;
  assign div_q_i         = dm_done ? dm_q : 32'hDEAD_BEEF;
  assign div_r_i         = dm_done ? dm_r : 32'hDEAD_BEEF;

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      dm_busy <= 1'b0; dm_done <= 1'b0; dm_cnt <= 0;
    end else if (!dm_busy) begin
      if (div_in_valid_o) begin
        {dm_q, dm_r} <= div_ref(div_signed_o, div_a_o, div_b_o);
        dm_busy    <= 1'b1;
        dm_cnt     <= 4;
        div_starts <= div_starts + 1;
      end
    end else if (!dm_done) begin
      if (dm_cnt == 0) dm_done <= 1'b1;
      else dm_cnt <= dm_cnt - 1;
    end else if (div_out_ready_o) begin
      dm_done <= 1'b0; dm_busy <= 1'b0;
    end
  end

  // Writeback monitor: every retired result must match the head of the scoreboard.
  always @(negedge clock) begin
    if (nreset && wb_valid_o) begin
      wb_seen = 1'b1;
      if (wb_ready_i && !flush_i) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL wb_unexpected got rd=%0d data=%h want no writeback", wb_rd_o, wb_data_o);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          if ({wb_rd_o, wb_data_o} !== e) begin
            mismatched++;
            $display("FAIL wb_result got rd=%0d data=%h want rd=%0d data=%h", wb_rd_o, wb_data_o, e[36:32], e[31:0]);
          end else begin
            $display("wb rd=%0d data=%h ok", wb_rd_o, wb_data_o);
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    while (!req_ready_o && n < 200) begin @(posedge clock); #1; n++; end
    if (!req_ready_o) begin
      compared++; mismatched++;
      $display("FAIL req_ready_timeout got 0 want 1");
    end
    req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
    @(posedge clock); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 200) begin @(posedge clock); #1; n++; end
    compared++;
    if (exp_q.size() != 0 || busy_o) begin
      mismatched++;
      $display("FAIL %s_drain_timeout got pending=%0d busy=%b want 0/0", name, exp_q.size(), busy_o);
    end
  endtask

  task automatic wait_out_ready(input string name);
    int n = 0;
    while (!div_out_ready_o && n < 100) begin @(posedge clock); #1; n++; end
    compared++;
    if (!div_out_ready_o) begin
      mismatched++;
      $display("FAIL %s_wait_timeout got out_ready=0 want 1", name);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    compared++;
    if ({req_ready_o, busy_o, wb_valid_o, div_in_valid_o, div_out_ready_o, div_signed_o} !== 6'b0 ||
        wb_data_o !== 32'd0 || wb_rd_o !== 5'd0 || div_a_o !== 32'd0 || div_b_o !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_outputs got ready=%b busy=%b wbv=%b inv=%b outr=%b data=%h want all 0",
               req_ready_o, busy_o, wb_valid_o, div_in_valid_o, div_out_ready_o, wb_data_o);
    end
    nreset = 1'b1;
    @(posedge clock); #1;
    compared++;
    if (req_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready got %b want 1", req_ready_o);
    end
    $display("reset done");
  endtask

  task automatic test_divider_path();
    int s0 = div_starts;
    exp_q.push_back({5'd3, 32'd14});
    send(2'b01, 32'd100, 32'd7, 5'd3);
    compared++;
    if (div_in_valid_o !== 1'b1 || div_a_o !== 32'd100 || div_b_o !== 32'd7 || div_signed_o !== 1'b0) begin
      mismatched++;
      $display("FAIL issue_operands got inv=%b a=%h b=%h s=%b want 1/64/7/0", div_in_valid_o, div_a_o, div_b_o, div_signed_o);
    end
    wait_drain("divu");
    compared++;
    if (div_starts !== s0 + 1) begin
      mismatched++;
      $display("FAIL divu_handshakes got %0d want %0d", div_starts - s0, 1);
    end
    exp_q.push_back({5'd17, 32'd2});
    send(2'b11, 32'd100, 32'd7, 5'd17);
    wait_drain("remu");
    exp_q.push_back({5'd4, 32'hFFFF_FFFD});
    send(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4);
    compared++;
    if (div_signed_o !== 1'b1) begin
      mismatched++;
      $display("FAIL div_signed got %b want 1", div_signed_o);
    end
    wait_drain("div_neg");
    exp_q.push_back({5'd5, 32'hFFFF_FFFF});
    send(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5);
    wait_drain("rem_neg");
    // Unsigned INT_MIN / all-ones is not a corner case and must use the divider.
    s0 = div_starts;
    exp_q.push_back({5'd6, 32'd0});
    send(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    wait_drain("divu_big");
    compared++;
    if (div_starts !== s0 + 1) begin
      mismatched++;
      $display("FAIL divu_big_handshakes got %0d want 1", div_starts - s0);
    end
  endtask

  task automatic special_case(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] want);
    int s0 = div_starts;
    exp_q.push_back({5'd9, want});
    send(op, a, b, 5'd9);
    compared++;
    if (wb_valid_o !== 1'b1 || div_in_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_latency got wbv=%b inv=%b want 1/0", name, wb_valid_o, div_in_valid_o);
    end
    wait_drain(name);
    compared++;
    if (div_starts !== s0) begin
      mismatched++;
      $display("FAIL %s_divider_used got %0d starts want 0", name, div_starts - s0);
    end
  endtask

  task automatic test_special();
    special_case("div_by0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    special_case("rem_by0", 2'b10, 32'd5, 32'd0, 32'd5);
    special_case("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    special_case("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    special_case("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_flush_wait();
    int n = 0;
    wb_seen = 1'b0;
    send(2'b01, 32'd50, 32'd5, 5'd11);
    wait_out_ready("flush");
    flush_i = 1'b1;
    @(posedge clock); #1;
    flush_i = 1'b0;
    compared++;
    if (busy_o !== 1'b0 || div_out_ready_o !== 1'b1 || req_ready_o !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_drain got busy=%b outr=%b ready=%b want 0/1/0", busy_o, div_out_ready_o, req_ready_o);
    end
    while (!req_ready_o && n < 100) begin @(posedge clock); #1; n++; end
    compared++;
    if (!req_ready_o || wb_seen) begin
      mismatched++;
      $display("FAIL flush_discard got ready=%b wb_seen=%b want 1/0", req_ready_o, wb_seen);
    end
    exp_q.push_back({5'd12, 32'd3});
    send(2'b01, 32'd9, 32'd3, 5'd12);
    wait_drain("after_flush");
    $display("flush in wait done");
  endtask

  task automatic test_stall();
    int n = 0;
    wb_ready_i = 1'b0;
    exp_q.push_back({5'd9, 32'd14});
    send(2'b01, 32'd100, 32'd7, 5'd9);
    while (!wb_valid_o && n < 100) begin @(posedge clock); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (wb_valid_o !== 1'b1 || wb_data_o !== 32'd14 || wb_rd_o !== 5'd9 || req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_hold cyc=%0d got v=%b data=%h rd=%0d ready=%b busy=%b want 1/0000000e/9/0/1",
                 i, wb_valid_o, wb_data_o, wb_rd_o, req_ready_o, busy_o);
      end
      @(posedge clock); #1;
    end
    wb_ready_i = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_reset_mid();
    send(2'b01, 32'd1000, 32'd3, 5'd21);
    wait_out_ready("rst_mid");
    nreset = 1'b0;
    #1;
    compared++;
    if ({req_ready_o, busy_o, wb_valid_o, div_in_valid_o, div_out_ready_o, div_signed_o} !== 6'b0 ||
        wb_data_o !== 32'd0 || wb_rd_o !== 5'd0 || div_a_o !== 32'd0 || div_b_o !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_mid got ready=%b busy=%b outr=%b a=%h b=%h want all 0",
               req_ready_o, busy_o, div_out_ready_o, div_a_o, div_b_o);
    end
    @(posedge clock); #1;
    nreset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    compared++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_recover got ready=%b busy=%b want 1/0", req_ready_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b, want;
      logic [63:0] e;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : 32'($urandom_range(1, 50));
      e  = div_ref(!op[0], a, b);
      want = op[1] ? e[31:0] : e[63:32];
      exp_q.push_back({5'(i + 1), want});
      send(op, a, b, 5'(i + 1));
    end
    wait_drain("b2b");
  endtask

  initial begin
    nreset = 1'b0; req_valid_i = 1'b0; req_op_i = 2'b00; req_rs1_i = '0; req_rs2_i = '0;
    req_rd_i = '0; flush_i = 1'b0; wb_ready_i = 1'b1;
    test_reset();
    test_divider_path();
    test_special();
    test_flush_wait();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_left got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
